// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the SRAM slave: bus codes, FSM states
// and the little-endian byte-lane decode.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } sramState_t;

    function automatic logic [3:0] laneStrobe(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] strobe;
        strobe = 4'b0000;
        case (size)
            HSIZE_BYTE: strobe = 4'b0001 << addr;
            HSIZE_HALF: strobe = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: strobe = 4'b1111;
            default:    strobe = 4'b0000;
        endcase
        return strobe;
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised SRAM storage: one byte-enabled write port and one
// synchronous read-first read port.
module ahb_sram_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [3:0]            i_wstrb,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [31:0]           i_wdata,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [31:0]           o_rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0] r_mem [0:DEPTH-1];
    logic [31:0] r_rdata;

    // A read and a write to the same word on one edge returns the old contents.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_wstrb[i]) begin
                    r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ahb_sram.sv
// AHB-Lite SRAM slave: address/data-phase control, configurable wait states,
// two-cycle ERROR response and write-to-read bypass around the array.
module ahb_sram
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic        hmastlock,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int         WORD_BITS = ADDR_WIDTH - 2;
    localparam logic [1:0] WAIT_LOAD = 2'(WAIT_STATES);

    sramState_t            r_state;
    sramState_t            w_nextState;
    logic [1:0]            r_waitCnt;
    logic [1:0]            w_nextWaitCnt;
    logic                  r_dpValid;
    logic                  r_dpWrite;
    logic [2:0]            r_dpSize;
    logic [ADDR_WIDTH-1:0] r_dpAddr;
    logic                  r_bypHit;
    logic [3:0]            r_bypStrb;
    logic [31:0]           r_bypData;

    logic                  w_addrReady;
    logic                  w_accept;
    logic                  w_error;
    logic                  w_lastCycle;
    logic                  w_we;
    logic                  w_re;
    logic [3:0]            w_wstrb;
    logic [31:0]           w_arrayData;
    logic [31:0]           w_mergedData;
    logic                  w_unused;

    assign w_unused = ^{hburst, hprot, hmastlock};

    assign w_addrReady = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
    assign w_accept    = hsel && hready && w_addrReady &&
                         ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    assign w_error     = (hsize > HSIZE_WORD) ||
                         ((hsize == HSIZE_HALF) && haddr[0]) ||
                         ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00)) ||
                         (haddr[31:ADDR_WIDTH] != '0);

    // r_dpValid marks an OKAY data phase; errored transfers live only in the ERR states.
    assign w_lastCycle = r_dpValid && ((r_state == S_IDLE) || (r_state == S_DATA));
    assign w_wstrb     = laneStrobe(r_dpSize, r_dpAddr[1:0]);
    assign w_we        = w_lastCycle && r_dpWrite;
    assign w_re        = w_accept && !hwrite && !w_error;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dpValid <= 1'b0;
            r_dpWrite <= 1'b0;
            r_dpSize  <= 3'd0;
            r_dpAddr  <= '0;
        end else if (w_addrReady) begin
            r_dpValid <= w_accept && !w_error;
            if (w_accept) begin
                r_dpWrite <= hwrite;
                r_dpSize  <= hsize;
                r_dpAddr  <= haddr[ADDR_WIDTH-1:0];
            end
        end
    end

    // A write committing on the same edge as a read's array access is captured for merging.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bypHit  <= 1'b0;
            r_bypStrb <= 4'b0000;
            r_bypData <= 32'h0;
        end else if (w_re) begin
            r_bypHit  <= w_we && (r_dpAddr[ADDR_WIDTH-1:2] == haddr[ADDR_WIDTH-1:2]);
            r_bypStrb <= w_wstrb;
            r_bypData <= hwdata;
        end
    end

    ahb_sram_array #(
        .DEPTH_LOG2(WORD_BITS)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_wstrb (w_wstrb),
        .i_waddr (r_dpAddr[ADDR_WIDTH-1:2]),
        .i_wdata (hwdata),
        .i_re    (w_re),
        .i_raddr (haddr[ADDR_WIDTH-1:2]),
        .o_rdata (w_arrayData)
    );

    always_comb begin
        w_mergedData = w_arrayData;
        for (int i = 0; i < 4; i++) begin
            if (r_bypHit && r_bypStrb[i]) begin
                w_mergedData[8*i +: 8] = r_bypData[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_waitCnt <= 2'd0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWaitCnt;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_nextWaitCnt = r_waitCnt;
        case (r_state)
            S_IDLE, S_DATA, S_ERR2: begin
                w_nextState   = S_IDLE;
                w_nextWaitCnt = 2'd0;
                if (w_accept) begin
                    if (w_error) begin
                        w_nextState = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        w_nextState   = S_WAIT;
                        w_nextWaitCnt = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (r_waitCnt <= 2'd1) begin
                    w_nextState   = S_DATA;
                    w_nextWaitCnt = 2'd0;
                end else begin
                    w_nextWaitCnt = r_waitCnt - 2'd1;
                end
            end
            S_ERR1:  w_nextState = S_ERR2;
            default: w_nextState = S_IDLE;
        endcase
    end

    assign hreadyout = !((r_state == S_WAIT) || (r_state == S_ERR1));
    assign hresp     = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign hrdata    = (w_lastCycle && !r_dpWrite) ? w_mergedData : 32'h0;

endmodule
